tag_scan_loader: RTL and testbench
==================================

TAG_SCAN_LOADER -- requirements
Module: tag_scan_loader

Interface
REQ-001 SHALL have parameter TX_BITS_WIDTH, default 128: width of the parallel hop-code word.
REQ-002 SHALL have parameter NTX_BITS, default 78: number of bits shifted per load, where 1 <= NTX_BITS <= TX_BITS_WIDTH.
REQ-003 SHALL have parameter BIT_CNT_WIDTH, default 7: bit-counter width, where 2^BIT_CNT_WIDTH > NTX_BITS.
REQ-004 SHALL have parameter CLK_DIV, default 20: clk cycles per scan tick, where CLK_DIV >= 2.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic runs on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: load request, sampled every clk.
REQ-008 SHALL have port data_in, input, TX_BITS_WIDTH bits: hop code; bits [NTX_BITS-1:0] are used.
REQ-009 SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-clk pulse when a load completes.
REQ-011 SHALL have port scan_id, output, 1 bit: chip scan select.
REQ-012 SHALL have port scan_phi, output, 1 bit: scan clock phase 1.
REQ-013 SHALL have port scan_phi_bar, output, 1 bit: scan clock phase 2.
REQ-014 SHALL have port scan_data_in, output, 1 bit: serial data to the chip.
REQ-015 SHALL have port scan_load_chip, output, 1 bit: parallel-load strobe.
REQ-016 SHALL have port nbits_cnt, output, BIT_CNT_WIDTH bits: count of bits shifted in the current or last load.

Function
REQ-017 SHALL accept start only in IDLE; on acceptance it SHALL capture data_in[NTX_BITS-1:0] into a shift register, clear nbits_cnt, clear the tick divider and enter SETUP on the next clk.
REQ-018 SHALL ignore start while busy=1; the captured word SHALL be unaffected by data_in changes after acceptance.
REQ-019 SHALL generate tick: divider counts 0..CLK_DIV-1 from state entry; every non-IDLE state lasts exactly CLK_DIV clks.
REQ-020 SHALL use states IDLE, SETUP, PHI, GAP_A, PHIB, GAP_B, LOAD, FINISH.
REQ-021 Transitions: SETUP->PHI; PHI->GAP_A; GAP_A->PHIB; PHIB->GAP_B; GAP_B->PHI if nbits_cnt<NTX_BITS, else LOAD; LOAD->FINISH; FINISH->IDLE; each transition fires on the final clk of the state.
REQ-022 SHALL shift MSB first: scan_data_in = captured bit NTX_BITS-1 from SETUP entry; the shift register advances one bit on GAP_B entry.
REQ-023 SHALL increment nbits_cnt by 1 on each PHIB->GAP_B transition; nbits_cnt SHALL saturate at NTX_BITS and hold after done until the next accepted start.
REQ-024 SHALL drive scan_phi=1 only in PHI, scan_phi_bar=1 only in PHIB, and never both; GAP_A and GAP_B give a CLK_DIV-clk non-overlap interval.
REQ-025 SHALL drive scan_id=1 in every state SETUP through LOAD inclusive, and 0 in FINISH and IDLE.
REQ-026 SHALL drive scan_load_chip=1 only in LOAD; scan_data_in SHALL be 0 in LOAD, FINISH and IDLE.
REQ-027 SHALL drive busy=1 in all non-IDLE states; a load occupies CLK_DIV*(4*NTX_BITS+3) clks from SETUP entry to IDLE re-entry.
REQ-028 SHALL pulse done=1 for exactly one clk, in the first IDLE clk after FINISH; a start in that same clk SHALL be accepted.
REQ-029 All outputs SHALL be registered, with no combinational path from start or data_in.

Reset
REQ-030 On reset, including mid-load, SHALL enter IDLE and set busy, done, scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip, nbits_cnt, the divider and the shift register to 0.
REQ-031 Reset SHALL take priority over start in the same clk; start is honoured from the first clk after reset deasserts.

Verification
REQ-032 Bench SHALL cover: NTX_BITS=4, CLK_DIV=2, data_in=4'b1011, start pulse -> scan_data_in 1,0,1,1 stable across each PHI; 4 phi and 4 phi_bar pulses of 2 clks each; load strobe of 2 clks; done 38 clks after SETUP entry; nbits_cnt=4.
REQ-033 Bench SHALL cover: default parameters, data_in=78'h2A...A -> 78 phi pulses, alternating bits MSB first, busy for 20*315=6300 clks, single done pulse.
REQ-034 Bench SHALL cover: start held high continuously -> back-to-back loads, new SETUP in the clk after done, with no second capture mid-load.
REQ-035 Bench SHALL cover: data_in changed and start re-pulsed during a load -> shifted bits equal the originally captured word.
REQ-036 Bench SHALL cover: reset asserted during PHI of bit 10 -> the next clk has all outputs 0 and state IDLE; a following start runs a full, correct load.
REQ-037 Bench SHALL cover: continuous assertion checks -> never scan_phi&scan_phi_bar; scan_data_in changes only when both phases are 0.

Source files
------------

// File: rtl/tag_scan_loader.sv
// Serial scan loader: captures a hop code and shifts it MSB first into a chip scan chain
// using two non-overlapping scan clock phases, then strobes the chip's parallel load.
module tag_scan_loader #(
  parameter int unsigned TX_BITS_WIDTH = 128,
  parameter int unsigned NTX_BITS      = 78,
  parameter int unsigned BIT_CNT_WIDTH = 7,
  parameter int unsigned CLK_DIV       = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TX_BITS_WIDTH-1:0] data_in,
  output logic                     busy,
  output logic                     done,
  output logic                     scan_id,
  output logic                     scan_phi,
  output logic                     scan_phi_bar,
  output logic                     scan_data_in,
  output logic                     scan_load_chip,
  output logic [BIT_CNT_WIDTH-1:0] nbits_cnt
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] NBits = BIT_CNT_WIDTH'(NTX_BITS);

  typedef enum logic [2:0] {
    StIdle, StSetup, StPhi, StGapA, StPhib, StGapB, StLoad, StFinish
  } state_e;

  state_e                   state_q, state_d;
  logic [DivW-1:0]          div_q, div_d;
  logic [NTX_BITS-1:0]      sr_q, sr_d;
  logic [BIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     busy_q, done_q, id_q, phi_q, phib_q, sdi_q, load_q;
  logic                     last_tick;
  logic                     shifting_d;

  // Only the low NTX_BITS of the hop code are loaded.
  logic unused_data;
  assign unused_data = ^data_in;

  assign last_tick = (div_q == DivMax);

  always_comb begin
    state_d = state_q;
    div_d   = last_tick ? '0 : div_q + 1'b1;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          state_d = StSetup;
          sr_d    = data_in[NTX_BITS-1:0];
          cnt_d   = '0;
        end
      end
      StSetup:  if (last_tick) state_d = StPhi;
      StPhi:    if (last_tick) state_d = StGapA;
      StGapA:   if (last_tick) state_d = StPhib;
      StPhib: begin
        if (last_tick) begin
          state_d = StGapB;
          sr_d    = sr_q << 1;
          if (cnt_q < NBits) cnt_d = cnt_q + 1'b1;
        end
      end
      StGapB:   if (last_tick) state_d = (cnt_q < NBits) ? StPhi : StLoad;
      StLoad:   if (last_tick) state_d = StFinish;
      StFinish: if (last_tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign shifting_d = state_d inside {StSetup, StPhi, StGapA, StPhib, StGapB};

  // Outputs are decoded from next state so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= 1'b0;
      phi_q   <= 1'b0;
      phib_q  <= 1'b0;
      sdi_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_q == StFinish) && (state_d == StIdle);
      id_q    <= shifting_d || (state_d == StLoad);
      phi_q   <= (state_d == StPhi);
      phib_q  <= (state_d == StPhib);
      sdi_q   <= shifting_d ? sr_d[NTX_BITS-1] : 1'b0;
      load_q  <= (state_d == StLoad);
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign scan_id        = id_q;
  assign scan_phi       = phi_q;
  assign scan_phi_bar   = phib_q;
  assign scan_data_in   = sdi_q;
  assign scan_load_chip = load_q;
  assign nbits_cnt      = cnt_q;

endmodule

// File: tb/tb_tag_scan_loader.sv
// Directed bench for tag_scan_loader: a small (4-bit, divide-by-2) instance checked cycle by
// cycle and a default-parameter instance checked by pulse counts and shifted bit order.
`timescale 1ns/1ps
module tb_tag_scan_loader;
  localparam int unsigned SDIV = 2;
  localparam int unsigned DN   = 78;
  localparam int unsigned DW   = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       s_start = 1'b0;
  logic [7:0] s_data  = '0;
  logic       s_busy, s_done, s_id, s_phi, s_phib, s_sdi, s_load;
  logic [2:0] s_cnt;

  logic          d_start = 1'b0;
  logic [DW-1:0] d_data  = '0;
  logic          d_busy, d_done, d_id, d_phi, d_phib, d_sdi, d_load;
  logic [6:0]    d_cnt;

  int tests_run = 0;
  int fails = 0;
  int asrt_fails = 0;

  always #5 clk = ~clk;

  tag_scan_loader #(
    .TX_BITS_WIDTH(8), .NTX_BITS(4), .BIT_CNT_WIDTH(3), .CLK_DIV(SDIV)
  ) u_small (
    .clk(clk), .reset(reset), .start(s_start), .data_in(s_data),
    .busy(s_busy), .done(s_done), .scan_id(s_id), .scan_phi(s_phi),
    .scan_phi_bar(s_phib), .scan_data_in(s_sdi), .scan_load_chip(s_load),
    .nbits_cnt(s_cnt)
  );

  tag_scan_loader u_dflt (
    .clk(clk), .reset(reset), .start(d_start), .data_in(d_data),
    .busy(d_busy), .done(d_done), .scan_id(d_id), .scan_phi(d_phi),
    .scan_phi_bar(d_phib), .scan_data_in(d_sdi), .scan_load_chip(d_load),
    .nbits_cnt(d_cnt)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] bits;  // expected serial order, bits[3] shifted first
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] s_sample();
    return {s_busy, s_done, s_id, s_phi, s_phib, s_sdi, s_load, s_cnt};
  endfunction

  function automatic logic [13:0] d_sample();
    return {d_busy, d_done, d_id, d_phi, d_phib, d_sdi, d_load, d_cnt};
  endfunction

  // Expected small-instance outputs k clks after SETUP entry.
  function automatic logic [9:0] s_exp(input int k, input logic [3:0] b);
    logic busy, done, id, phi, phib, sdi, load;
    logic [2:0] cnt;
    int s, bi, ph;
    busy = 0; done = 0; id = 0; phi = 0; phib = 0; sdi = 0; load = 0; cnt = 0;
    s = k / SDIV;
    if (s == 0) begin
      busy = 1; id = 1; sdi = b[3];
    end else if (s <= 16) begin
      bi = (s - 1) / 4;
      ph = (s - 1) % 4;
      busy = 1; id = 1;
      phi  = (ph == 0);
      phib = (ph == 2);
      if (ph == 3) begin
        cnt = 3'(bi + 1);
        sdi = (bi < 3) ? b[2-bi] : 1'b0;
      end else begin
        cnt = 3'(bi);
        sdi = b[3-bi];
      end
    end else if (s == 17) begin
      busy = 1; id = 1; load = 1; cnt = 4;
    end else if (s == 18) begin
      busy = 1; cnt = 4;
    end else begin
      done = (k == 38); cnt = 4;
    end
    return {busy, done, id, phi, phib, sdi, load, cnt};
  endfunction

  // Phase overlap and data-while-clocking watchdog.
  logic s_sdi_prev = 1'b0;
  logic d_sdi_prev = 1'b0;
  always @(negedge clk) begin
    if ((s_phi && s_phib) || (d_phi && d_phib)) begin
      asrt_fails++;
      $display("FAIL phase overlap at %0t: small %b%b, default %b%b", $time, s_phi, s_phib,
               d_phi, d_phib);
    end
    if ((s_sdi !== s_sdi_prev) && (s_phi || s_phib)) begin
      asrt_fails++;
      $display("FAIL small data moved under phase at %0t: sdi %b", $time, s_sdi);
    end
    if ((d_sdi !== d_sdi_prev) && (d_phi || d_phib)) begin
      asrt_fails++;
      $display("FAIL default data moved under phase at %0t: sdi %b", $time, d_sdi);
    end
    s_sdi_prev <= s_sdi;
    d_sdi_prev <= d_sdi;
  end

  task automatic run_small(input vec_t v, input int idx);
    @(negedge clk);
    s_data  = v.data;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_data  = ~v.data;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("small v%0d k%0d", idx, k), 64'(s_sample()), 64'(s_exp(k, v.bits)));
    end
  endtask

  task automatic run_default(input logic [DW-1:0] d, input bit disturb, input string tag);
    int busy_n = 0, phi_n = 0, done_n = 0, bit_err = 0, done_k = -1;
    logic prev_phi = 1'b0;
    @(negedge clk);
    d_data  = d;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int k = 0; k < 6320; k++) begin
      if (k > 0) @(negedge clk);
      if (d_busy) busy_n++;
      if (d_done) begin
        done_n++;
        done_k = k;
      end
      if (d_phi && !prev_phi) begin
        if (phi_n < DN && d_sdi !== d[DN-1-phi_n]) bit_err++;
        phi_n++;
      end
      prev_phi = d_phi;
      if (disturb && k == 1000) begin
        d_data  = ~d;
        d_start = 1'b1;
      end
      if (disturb && k == 1001) d_start = 1'b0;
    end
    check({tag, " busy clks"}, 64'(busy_n), 64'd6300);
    check({tag, " phi pulses"}, 64'(phi_n), 64'd78);
    check({tag, " done pulses"}, 64'(done_n), 64'd1);
    check({tag, " done clk"}, 64'(done_k), 64'd6300);
    check({tag, " bit errors"}, 64'(bit_err), 64'd0);
    check({tag, " nbits_cnt"}, 64'(d_cnt), 64'd78);
  endtask

  vec_t vecs[5];
  logic [DW-1:0] alt;
  logic [DW-1:0] pat;

  initial begin
    vecs[0] = '{data: 8'hAB, bits: 4'b1011};
    vecs[1] = '{data: 8'hF0, bits: 4'b0000};
    vecs[2] = '{data: 8'h5F, bits: 4'b1111};
    vecs[3] = '{data: 8'hC6, bits: 4'b0110};
    vecs[4] = '{data: 8'h38, bits: 4'b1000};
    alt = '0;
    for (int i = 0; i < int'(DN); i++) alt[i] = i[0];
    pat = 128'h0000_0000_0000_3C5A_9E17_0F2D_C3B1_6E84;

    repeat (3) @(negedge clk);
    check("reset small outputs", 64'(s_sample()), 64'd0);
    check("reset default outputs", 64'(d_sample()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle small outputs", 64'(s_sample()), 64'd0);

    for (int i = 0; i < 5; i++) run_small(vecs[i], i);

    // Start held high: second capture only at the done clk, not mid-load.
    @(negedge clk);
    s_data  = 8'h0B;
    s_start = 1'b1;
    for (int k = 0; k < 79; k++) begin
      @(negedge clk);
      if (k < 39) check($sformatf("b2b first k%0d", k), 64'(s_sample()),
                        64'(s_exp(k, 4'b1011)));
      else check($sformatf("b2b second k%0d", k), 64'(s_sample()),
                 64'(s_exp(k - 39, 4'b0100)));
      if (k == 4) s_data = 8'h04;
      if (k == 39) s_start = 1'b0;
    end

    // Reset wins over start; start honoured on the first clk after release.
    @(negedge clk);
    s_data  = 8'h08;
    s_start = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    check("reset beats start", 64'(s_sample()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    check("start after reset", 64'(s_sample()), 64'(s_exp(0, 4'b1000)));
    repeat (40) @(negedge clk);

    run_default(alt, 1'b0, "alternating");
    run_default(pat, 1'b1, "disturbed");

    // Reset in PHI of bit 10, then a clean load.
    @(negedge clk);
    d_data  = alt;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    repeat (825) @(negedge clk);
    check("bit10 in phi", 64'(d_phi), 64'd1);
    check("bit10 nbits_cnt", 64'(d_cnt), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    check("mid-load reset outputs", 64'(d_sample()), 64'd0);
    reset = 1'b0;
    run_default(pat, 1'b0, "after reset");

    check("continuous phase checks", 64'(asrt_fails), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
